// File: rtl/wb_queue.sv
// Writeback queue: gathers up to IN results per cycle into a DEPTH-entry ring
// and drains the oldest WRITE entries onto active-low register-file write ports.
`timescale 1ns/1ps

module wb_queue_drain #(
  parameter int DATA = 32,
  parameter int ADDR = 4
) (
  input  logic            active,
  input  logic [ADDR-1:0] ent_addr,
  input  logic [DATA-1:0] ent_data,
  output logic            we_,
  output logic [ADDR-1:0] waddr,
  output logic [DATA-1:0] wdata
);
  // Idle ports are driven to zero so the register file sees a quiet bus.
  assign we_   = ~active;
  assign waddr = active ? ent_addr : '0;
  assign wdata = active ? ent_data : '0;
endmodule

module wb_queue #(
  parameter int DATA     = 32,
  parameter int ADDR     = 4,
  parameter int IN       = 2,
  parameter int WRITE    = 1,
  parameter int DEPTH    = 4,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset_,
  input  logic                            flush_,
  input  logic [IN-1:0]                   in_valid,
  input  logic [IN-1:0][ADDR-1:0]         in_addr,
  input  logic [IN-1:0][DATA-1:0]         in_data,
  output logic                            in_ready,
  output logic [WRITE-1:0]                we_,
  output logic [WRITE-1:0][ADDR-1:0]      waddr,
  output logic [WRITE-1:0][DATA-1:0]      wdata,
  output logic [(1<<ADDR)-1:0]            busy,
  output logic [$clog2(DEPTH):0]          count
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR;

  typedef struct packed {
    logic            vld;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] q, q_nxt;
  logic [PW-1:0]      head, tail, head_nxt, tail_nxt;
  logic [CW-1:0]      cnt, cnt_nxt, nenq, ndrain;
  logic [NREG-1:0]    busy_r, busy_nxt;

  // Ready looks only at registered occupancy; a same-cycle drain is not credited.
  assign in_ready = (CW'(DEPTH) - cnt) >= CW'(IN);
  assign ndrain   = (cnt < CW'(WRITE)) ? cnt : CW'(WRITE);
  assign count    = cnt;
  assign busy     = busy_r;

  for (genvar k = 0; k < WRITE; k++) begin : g_drain
    logic [PW-1:0] idx;
    assign idx = head + PW'(k);
    wb_queue_drain #(.DATA(DATA), .ADDR(ADDR)) u_drain (
      .active   (CW'(k) < ndrain),
      .ent_addr (q[idx].addr),
      .ent_data (q[idx].data),
      .we_      (we_[k]),
      .waddr    (waddr[k]),
      .wdata    (wdata[k])
    );
  end

  always_comb begin
    q_nxt    = q;
    head_nxt = head + PW'(ndrain);
    tail_nxt = tail;
    nenq     = '0;
    for (int k = 0; k < WRITE; k++)
      if (CW'(k) < ndrain) q_nxt[head + PW'(k)].vld = 1'b0;
    // Enqueued slots are always free slots, so they never collide with drained ones.
    if (in_ready) begin
      for (int i = 0; i < IN; i++) begin
        if (in_valid[i] && !(ZERO_REG && in_addr[i] == '0)) begin
          q_nxt[tail_nxt].vld  = 1'b1;
          q_nxt[tail_nxt].addr = in_addr[i];
          q_nxt[tail_nxt].data = in_data[i];
          tail_nxt = tail_nxt + PW'(1);
          nenq     = nenq + CW'(1);
        end
      end
    end
    cnt_nxt = cnt + nenq - ndrain;
    if (!flush_) begin
      for (int e = 0; e < DEPTH; e++) q_nxt[e].vld = 1'b0;
      head_nxt = '0;
      tail_nxt = '0;
      cnt_nxt  = '0;
    end
    busy_nxt = '0;
    for (int e = 0; e < DEPTH; e++)
      if (q_nxt[e].vld) busy_nxt[q_nxt[e].addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      q      <= '0;
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      busy_r <= '0;
    end else begin
      q      <= q_nxt;
      head   <= head_nxt;
      tail   <= tail_nxt;
      cnt    <= cnt_nxt;
      busy_r <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: one instance with WRITE=1 and zero-register
// discard, one with WRITE=2 for same-address ordering; each feeds a small regfile.
`timescale 1ns/1ps

module tb_wb_queue;
  logic clk, reset_, flush_;
  logic [1:0]       in_valid;
  logic [1:0][3:0]  in_addr;
  logic [1:0][31:0] in_data;
  logic             in_ready;
  logic [0:0]       we_;
  logic [0:0][3:0]  waddr;
  logic [0:0][31:0] wdata;
  logic [15:0]      busy;
  logic [2:0]       count;

  logic             flush2_;
  logic [1:0]       in_valid2;
  logic [1:0][3:0]  in_addr2;
  logic [1:0][31:0] in_data2;
  logic             in_ready2;
  logic [1:0]       we2_;
  logic [1:0][3:0]  waddr2;
  logic [1:0][31:0] wdata2;
  logic [15:0]      busy2;
  logic [2:0]       count2;

  logic [31:0] rf  [16];
  logic [31:0] rf2 [16];
  int nvec = 0;
  int nerr = 0;

  wb_queue #(.DATA(32), .ADDR(4), .IN(2), .WRITE(1), .DEPTH(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .in_valid(in_valid), .in_addr(in_addr),
    .in_data(in_data), .in_ready(in_ready), .we_(we_), .waddr(waddr), .wdata(wdata),
    .busy(busy), .count(count));

  wb_queue #(.DATA(32), .ADDR(4), .IN(2), .WRITE(2), .DEPTH(4), .ZERO_REG(1'b0)) dut2 (
    .clk(clk), .reset_(reset_), .flush_(flush2_), .in_valid(in_valid2), .in_addr(in_addr2),
    .in_data(in_data2), .in_ready(in_ready2), .we_(we2_), .waddr(waddr2), .wdata(wdata2),
    .busy(busy2), .count(count2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file models: higher ports are applied last.
  always @(posedge clk) begin
    for (int k = 0; k < 1; k++) if (!we_[k]) rf[waddr[k]] <= wdata[k];
    for (int k = 0; k < 2; k++) if (!we2_[k]) rf2[waddr2[k]] <= wdata2[k];
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    nvec++; if (we_ !== 1'b1) begin nerr++; $display("FAIL reset we_ got %b want 1", we_); end
    nvec++; if (busy !== 16'h0) begin nerr++; $display("FAIL reset busy got %h want 0", busy); end
    nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL reset count got %0d want 0", count); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    nvec++; if (waddr !== 4'h0 || wdata !== 32'h0) begin nerr++; $display("FAIL reset wbus got %h/%h want 0/0", waddr, wdata); end
    nvec++; if (we2_ !== 2'b11) begin nerr++; $display("FAIL reset we2_ got %b want 11", we2_); end
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_single_write;
    in_valid = 2'b01; in_addr[0] = 4'd3; in_data[0] = 32'hDEADBEEF;
    cyc();
    in_valid = 2'b00;
    nvec++; if (we_ !== 1'b0) begin nerr++; $display("FAIL single we_ got %b want 0", we_); end
    nvec++; if (waddr[0] !== 4'd3) begin nerr++; $display("FAIL single waddr got %0d want 3", waddr[0]); end
    nvec++; if (wdata[0] !== 32'hDEADBEEF) begin nerr++; $display("FAIL single wdata got %h want deadbeef", wdata[0]); end
    nvec++; if (busy !== 16'h0008) begin nerr++; $display("FAIL single busy got %h want 0008", busy); end
    cyc();
    nvec++; if (busy !== 16'h0) begin nerr++; $display("FAIL single busy_clr got %h want 0", busy); end
    nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL single count got %0d want 0", count); end
    nvec++; if (rf[3] !== 32'hDEADBEEF) begin nerr++; $display("FAIL single rf3 got %h want deadbeef", rf[3]); end
    nvec++; if (we_ !== 1'b1) begin nerr++; $display("FAIL single we_idle got %b want 1", we_); end
  endtask

  // Pairs n=(0,1),(1st edge) (2,3) (2nd) (4,5) held two edges; data 0x100+n to addr n+1.
  task automatic test_fill_wrap;
    logic [2:0]  exp_cnt  [7] = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
    logic        exp_rdy  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_busy [7] = '{16'h0006, 16'h001C, 16'h0018, 16'h0070, 16'h0060, 16'h0040, 16'h0000};
    for (int e = 0; e < 7; e++) begin
      int p;
      p = (e == 0) ? 0 : (e == 1) ? 1 : (e < 4) ? 2 : -1;
      if (p >= 0) begin
        in_valid = 2'b11;
        in_addr[0] = 4'(2*p + 1); in_data[0] = 32'h100 + 32'(2*p);
        in_addr[1] = 4'(2*p + 2); in_data[1] = 32'h101 + 32'(2*p);
      end else in_valid = 2'b00;
      cyc();
      nvec++; if (count !== exp_cnt[e]) begin nerr++; $display("FAIL fill count e%0d got %0d want %0d", e, count, exp_cnt[e]); end
      nvec++; if (in_ready !== exp_rdy[e]) begin nerr++; $display("FAIL fill in_ready e%0d got %b want %b", e, in_ready, exp_rdy[e]); end
      nvec++; if (busy !== exp_busy[e]) begin nerr++; $display("FAIL fill busy e%0d got %h want %h", e, busy, exp_busy[e]); end
      if (e < 6) begin
        nvec++;
        if (we_ !== 1'b0 || waddr[0] !== 4'(e + 1) || wdata[0] !== 32'h100 + 32'(e)) begin
          nerr++; $display("FAIL fill drain e%0d got we=%b a=%0d d=%h want we=0 a=%0d d=%h",
                           e, we_, waddr[0], wdata[0], e + 1, 32'h100 + 32'(e));
        end
      end else begin
        nvec++; if (we_ !== 1'b1) begin nerr++; $display("FAIL fill idle we_ got %b want 1", we_); end
      end
    end
  endtask

  task automatic test_zero_reg;
    in_valid = 2'b11;
    in_addr[0] = 4'd0; in_data[0] = 32'h11;
    in_addr[1] = 4'd5; in_data[1] = 32'h55;
    cyc();
    in_valid = 2'b00;
    nvec++; if (count !== 3'd1) begin nerr++; $display("FAIL zero count got %0d want 1", count); end
    nvec++; if (busy !== 16'h0020) begin nerr++; $display("FAIL zero busy got %h want 0020", busy); end
    nvec++; if (we_ !== 1'b0 || waddr[0] !== 4'd5 || wdata[0] !== 32'h55) begin
      nerr++; $display("FAIL zero drain got we=%b a=%0d d=%h want we=0 a=5 d=55", we_, waddr[0], wdata[0]); end
    cyc();
    nvec++; if (count !== 3'd0 || we_ !== 1'b1) begin nerr++; $display("FAIL zero empty got cnt=%0d we=%b want 0/1", count, we_); end
    nvec++; if (busy !== 16'h0) begin nerr++; $display("FAIL zero busy_end got %h want 0", busy); end
  endtask

  task automatic test_same_addr;
    in_valid2 = 2'b11;
    in_addr2[0] = 4'd7; in_data2[0] = 32'h1;
    in_addr2[1] = 4'd7; in_data2[1] = 32'h2;
    cyc();
    in_valid2 = 2'b00;
    nvec++; if (count2 !== 3'd2) begin nerr++; $display("FAIL same count got %0d want 2", count2); end
    nvec++; if (we2_ !== 2'b00) begin nerr++; $display("FAIL same we_ got %b want 00", we2_); end
    nvec++; if (waddr2[0] !== 4'd7 || waddr2[1] !== 4'd7) begin nerr++; $display("FAIL same waddr got %h want 77", waddr2); end
    nvec++; if (wdata2[0] !== 32'h1 || wdata2[1] !== 32'h2) begin nerr++; $display("FAIL same wdata got %h/%h want 1/2", wdata2[0], wdata2[1]); end
    nvec++; if (busy2 !== 16'h0080) begin nerr++; $display("FAIL same busy got %h want 0080", busy2); end
    cyc();
    nvec++; if (rf2[7] !== 32'h2) begin nerr++; $display("FAIL same rf7 got %h want 2", rf2[7]); end
    nvec++; if (count2 !== 3'd0 || busy2 !== 16'h0) begin nerr++; $display("FAIL same empty got cnt=%0d busy=%h want 0/0", count2, busy2); end
  endtask

  task automatic test_flush;
    in_valid = 2'b11;
    in_addr[0] = 4'd8;  in_data[0] = 32'hA0;
    in_addr[1] = 4'd9;  in_data[1] = 32'hA1;
    cyc();
    in_addr[0] = 4'd10; in_data[0] = 32'hA2;
    in_addr[1] = 4'd11; in_data[1] = 32'hA3;
    cyc();
    nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL flush pre_count got %0d want 3", count); end
    nvec++; if (we_ !== 1'b0 || wdata[0] !== 32'hA1) begin nerr++; $display("FAIL flush head got we=%b d=%h want 0/a1", we_, wdata[0]); end
    flush_ = 1'b0;
    in_addr[0] = 4'd12; in_data[0] = 32'hB0;
    in_addr[1] = 4'd13; in_data[1] = 32'hB1;
    cyc();
    nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL flush count got %0d want 0", count); end
    nvec++; if (busy !== 16'h0) begin nerr++; $display("FAIL flush busy got %h want 0", busy); end
    nvec++; if (we_ !== 1'b1) begin nerr++; $display("FAIL flush we_ got %b want 1", we_); end
    nvec++; if (rf[9] !== 32'hA1) begin nerr++; $display("FAIL flush rf9 got %h want a1", rf[9]); end
    // Queue is empty and ready now; flush must still block the enqueue.
    cyc();
    nvec++; if (count !== 3'd0 || busy !== 16'h0) begin nerr++; $display("FAIL flush suppress got cnt=%0d busy=%h want 0/0", count, busy); end
    flush_ = 1'b1; in_valid = 2'b00;
  endtask

  task automatic test_reset_mid;
    in_valid = 2'b11;
    in_addr[0] = 4'd12; in_data[0] = 32'hC0;
    in_addr[1] = 4'd13; in_data[1] = 32'hC1;
    cyc();
    in_valid = 2'b00;
    nvec++; if (count !== 3'd2) begin nerr++; $display("FAIL rstmid pre_count got %0d want 2", count); end
    #2 reset_ = 1'b0;
    #1;
    nvec++; if (we_ !== 1'b1) begin nerr++; $display("FAIL rstmid we_ got %b want 1", we_); end
    nvec++; if (busy !== 16'h0) begin nerr++; $display("FAIL rstmid busy got %h want 0", busy); end
    nvec++; if (count !== 3'd0 || in_ready !== 1'b1) begin nerr++; $display("FAIL rstmid cnt/rdy got %0d/%b want 0/1", count, in_ready); end
    @(negedge clk);
    reset_ = 1'b1;
    cyc();
    nvec++; if (count !== 3'd0 || we_ !== 1'b1) begin nerr++; $display("FAIL rstmid after got cnt=%0d we=%b want 0/1", count, we_); end
  endtask

  initial begin
    reset_ = 1'b0; flush_ = 1'b1; flush2_ = 1'b1;
    in_valid = '0; in_addr = '0; in_data = '0;
    in_valid2 = '0; in_addr2 = '0; in_data2 = '0;
    test_reset();
    test_single_write();
    test_fill_wrap();
    test_zero_reg();
    test_same_addr();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
